// File: rtl/reaction_ctrl.sv
// Reaction-timer game sequencer: drives the countdown, lights the LED and times the press.
// Optional best-time tracking is enabled by defining BEST_TIME_EN.
module reaction_ctrl #(
  parameter int MAX_TIME = 999,
  parameter int MIN_WAIT = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       react_btn,
  input  logic [8:0] lfsr_value,
  input  logic       cd_done,
  output logic [1:0] cd_state,
  output logic [8:0] cd_start,
  output logic       led,
  output logic [9:0] react_time,
  output logic       time_valid,
`ifdef BEST_TIME_EN
  output logic [9:0] best_time,
`endif
  output logic       early
);

  localparam logic [9:0] MAX_T = 10'(MAX_TIME);
  localparam logic [8:0] MIN_W = 9'(MIN_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_REACT,
    S_SHOW
  } state_e;

  state_e     state_q, state_d;
  logic       start_q, react_q;
  logic [1:0] cd_state_q, cd_state_d;
  logic [8:0] cd_start_q, cd_start_d;
  logic       led_q, led_d;
  logic [9:0] rt_q, rt_d;
  logic       valid_q, valid_d;
  logic       early_q, early_d;
  logic [9:0] cnt_q, cnt_d;
  logic       start_edge, react_edge;
`ifdef BEST_TIME_EN
  logic [9:0] best_q, best_d;
`endif

  assign start_edge = start_btn & ~start_q;
  assign react_edge = react_btn & ~react_q;

  always_comb begin
    state_d    = state_q;
    cd_state_d = cd_state_q;
    cd_start_d = cd_start_q;
    led_d      = led_q;
    rt_d       = rt_q;
    valid_d    = valid_q;
    early_d    = early_q;
    cnt_d      = cnt_q;
`ifdef BEST_TIME_EN
    best_d     = best_q;
`endif
    unique case (state_q)
      S_IDLE, S_SHOW: begin
        if (start_edge) begin
          state_d    = S_LOAD;
          cd_state_d = 2'd1;
          cd_start_d = (lfsr_value < MIN_W) ? MIN_W : lfsr_value;
          early_d    = 1'b0;
          valid_d    = 1'b0;
          rt_d       = '0;
        end
      end
      S_LOAD: begin
        state_d    = S_WAIT;
        cd_state_d = 2'd2;
      end
      S_WAIT: begin
        // A press beats a simultaneous cd_done: it is still a false start.
        if (react_edge) begin
          state_d    = S_SHOW;
          cd_state_d = 2'd3;
          early_d    = 1'b1;
          rt_d       = MAX_T;
          valid_d    = 1'b0;
        end else if (cd_done) begin
          state_d    = S_REACT;
          cd_state_d = 2'd3;
          led_d      = 1'b1;
          cnt_d      = '0;
        end
      end
      S_REACT: begin
        if (react_edge) begin
          state_d = S_SHOW;
          rt_d    = cnt_q;
          valid_d = 1'b1;
          led_d   = 1'b0;
`ifdef BEST_TIME_EN
          if (cnt_q < best_q) best_d = cnt_q;
`endif
        end else if (cnt_q == MAX_T) begin
          state_d = S_SHOW;
          rt_d    = MAX_T;
          valid_d = 1'b0;
          early_d = 1'b0;
          led_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        cd_state_d = 2'd0;
        led_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      react_q    <= 1'b0;
      cd_state_q <= 2'd0;
      cd_start_q <= '0;
      led_q      <= 1'b0;
      rt_q       <= '0;
      valid_q    <= 1'b0;
      early_q    <= 1'b0;
      cnt_q      <= '0;
`ifdef BEST_TIME_EN
      best_q     <= MAX_T;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_btn;
      react_q    <= react_btn;
      cd_state_q <= cd_state_d;
      cd_start_q <= cd_start_d;
      led_q      <= led_d;
      rt_q       <= rt_d;
      valid_q    <= valid_d;
      early_q    <= early_d;
      cnt_q      <= cnt_d;
`ifdef BEST_TIME_EN
      best_q     <= best_d;
`endif
    end
  end

  assign cd_state   = cd_state_q;
  assign cd_start   = cd_start_q;
  assign led        = led_q;
  assign react_time = rt_q;
  assign time_valid = valid_q;
  assign early      = early_q;
`ifdef BEST_TIME_EN
  assign best_time  = best_q;
`endif

endmodule
